if_fetch_sequencer: RTL and testbench

Controller for the instruction-fetch stage. It accepts an algorithm launch request and drives the stage's address-mux select (sel_dir) and PC-mux select (sel_pc). It also drives a PC-register enable. It qualifies the synchronous-ROM output toward decode with a valid/ready handshake and a one-entry skid register. It ends a run on a HALT opcode, a watchdog overrun or an abort.

---
 rtl/if_fetch_sequencer.sv | 116 +++++++++++
 tb/tb_if_fetch_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_sequencer.sv
// Instruction-fetch controller: launches an algorithm, steers the PC/address muxes and
// forwards synchronous-ROM words to decode through a valid/ready handshake with a one-entry skid.
module if_fetch_sequencer #(
   parameter logic [3:0] HALT_OP   = 4'b1111,
   parameter int         MAX_INSTR = 64,
   parameter int         CNT_W     = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       algo_sel,
   input  logic             abort,
   input  logic [13:0]      instruccion,
   input  logic [3:0]       opcode,
   input  logic             instr_ready,
   output logic [2:0]       sel_dir,
   output logic             sel_pc,
   output logic             pc_en,
   output logic [13:0]      instr_out,
   output logic             instr_valid,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_JUMP = 3'd1;
   localparam logic [2:0] S_FILL = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [2:0]       algo_q;
   logic [13:0]      skid_q;
   logic             skid_full;
   logic [CNT_W-1:0] cnt_q;

   logic [13:0] src_word;
   logic [3:0]  src_op;
   logic        src_halt;
   logic        in_run;
   logic        accept;
   logic        wd_hit;
   logic        launch;

   // While the skid holds a word it is the head of the stream; the ROM output behind it is the next word.
   assign src_word = skid_full ? skid_q : instruccion;
   assign src_op   = skid_full ? skid_q[13:10] : opcode;
   assign src_halt = (src_op == HALT_OP);
   assign in_run   = (state == S_RUN);
   assign launch   = (state == S_IDLE) && start && !abort;

   assign instr_valid = in_run && !src_halt;
   assign instr_out   = instr_valid ? src_word : 14'd0;
   assign accept      = instr_valid && instr_ready;
   assign wd_hit      = accept && (cnt_q == CNT_W'(MAX_INSTR - 1));

   assign sel_dir     = algo_q;
   assign sel_pc      = (state == S_JUMP);
   assign pc_en       = (state == S_JUMP) || (state == S_FILL) || accept;
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);
   assign error       = wd_hit && !abort;
   assign instr_count = cnt_q;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_JUMP;
         S_JUMP:  state_nxt = S_FILL;
         S_FILL:  state_nxt = S_RUN;
         S_RUN: begin
            // HALT cannot be accepted, so it always takes precedence over the watchdog.
            if (src_halt)    state_nxt = S_DONE;
            else if (wd_hit) state_nxt = S_IDLE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         algo_q    <= 3'd0;
         skid_full <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state <= state_nxt;
         if (launch) begin
            algo_q <= algo_sel;
            cnt_q  <= '0;
         end else if (accept && !abort) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (abort || !in_run || wd_hit) begin
            skid_full <= 1'b0;
         end else if (skid_full && instr_ready) begin
            skid_full <= 1'b0;
         end else if (!skid_full && instr_valid && !instr_ready) begin
            skid_full <= 1'b1;
         end
      end
   end

   // Payload only; its validity is carried entirely by skid_full.
   always_ff @(posedge clk) begin
      if (in_run && !skid_full && instr_valid && !instr_ready && !abort) begin
         skid_q <= instruccion;
      end
   end

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Directed bench for if_fetch_sequencer with a behavioural PC/sync-ROM fetch stage
// and an in-order scoreboard of the words decode should receive.
module tb_if_fetch_sequencer;

   localparam logic [3:0] HALT_OP   = 4'hF;
   localparam int         MAX_INSTR = 4;
   localparam int         CNT_W     = 7;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [2:0]       algo_sel = 3'd0;
   logic             abort = 1'b0;
   logic [13:0]      instruccion = 14'd0;
   logic [3:0]       opcode;
   logic             instr_ready = 1'b0;
   logic [2:0]       sel_dir;
   logic             sel_pc;
   logic             pc_en;
   logic [13:0]      instr_out;
   logic             instr_valid;
   logic             busy;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] instr_count;

   int vectors = 0;
   int miscompares = 0;

   logic [13:0] rom [64];
   logic [5:0]  pc = 6'd0;
   logic [13:0] exp_q [$];

   if_fetch_sequencer #(
      .HALT_OP  (HALT_OP),
      .MAX_INSTR(MAX_INSTR),
      .CNT_W    (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .algo_sel   (algo_sel),
      .abort      (abort),
      .instruccion(instruccion),
      .opcode     (opcode),
      .instr_ready(instr_ready),
      .sel_dir    (sel_dir),
      .sel_pc     (sel_pc),
      .pc_en      (pc_en),
      .instr_out  (instr_out),
      .instr_valid(instr_valid),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Fetch-stage model: base address of algorithm k is 2*k; ROM output registered every cycle.
   assign opcode = instruccion[13:10];
   always @(posedge clk) begin
      instruccion <= rom[pc];
      if (pc_en) pc <= sel_pc ? {2'b00, sel_dir, 1'b0} : pc + 6'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic push_run(input int base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(rom[base + i]);
   endtask

   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_extra_word", 32'(instr_valid), 32'd0);
         end else begin
            logic [13:0] w;
            w = exp_q.pop_front();
            chk("sb_word", 32'(instr_out), 32'(w));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = {4'(i % 15), 10'(i * 37)};
      rom[7]  = {HALT_OP, 10'h3A5};
      rom[16] = {HALT_OP, 10'h155};

      // Reset state
      #1;
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_sel_dir", 32'(sel_dir), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_out",   32'(instr_out), 32'd0);
      chk("rst_sel_pc", 32'(sel_pc), 32'd0);
      chk("rst_pc_en", 32'(pc_en), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      instr_ready = 1'b1;

      // Basic run: algo 2, base 4, HALT at 7
      start = 1'b1; algo_sel = 3'd2; push_run(4, 3);
      tick(); start = 1'b0; algo_sel = 3'd0;
      sample();
      chk("t1_jump_sel_pc", 32'(sel_pc), 32'd1);
      chk("t1_jump_sel_dir", 32'(sel_dir), 32'd2);
      chk("t1_jump_pc_en", 32'(pc_en), 32'd1);
      chk("t1_jump_busy", 32'(busy), 32'd1);
      tick(); sample();
      chk("t1_fill_sel_pc", 32'(sel_pc), 32'd0);
      chk("t1_fill_pc_en", 32'(pc_en), 32'd1);
      chk("t1_fill_valid", 32'(instr_valid), 32'd0);
      tick(); sample();
      chk("t1_first_valid", 32'(instr_valid), 32'd1);
      chk("t1_first_word", 32'(instr_out), 32'(rom[4]));
      tick(); tick(); tick(); sample();
      chk("t1_halt_valid", 32'(instr_valid), 32'd0);
      chk("t1_halt_pc_en", 32'(pc_en), 32'd0);
      chk("t1_halt_done", 32'(done), 32'd0);
      tick(); sample();
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_done_error", 32'(error), 32'd0);
      chk("t1_done_busy", 32'(busy), 32'd1);
      tick(); sample();
      chk("t1_idle_busy", 32'(busy), 32'd0);
      chk("t1_idle_done", 32'(done), 32'd0);
      chk("t1_count", 32'(instr_count), 32'd3);
      chk("t1_sb_drain", 32'(exp_q.size()), 32'd0);

      // Backpressure while ROM[5] is presented
      tick(); start = 1'b1; algo_sel = 3'd2; push_run(4, 3);
      tick(); start = 1'b0;
      tick(); tick();
      tick(); instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("t2_stall_word", 32'(instr_out), 32'(rom[5]));
         chk("t2_stall_pc_en", 32'(pc_en), 32'd0);
         chk("t2_stall_valid", 32'(instr_valid), 32'd1);
         tick();
      end
      instr_ready = 1'b1;
      sample();
      chk("t2_resume_word", 32'(instr_out), 32'(rom[5]));
      chk("t2_resume_pc_en", 32'(pc_en), 32'd1);
      tick(); sample();
      chk("t2_next_word", 32'(instr_out), 32'(rom[6]));
      tick(); sample();
      chk("t2_halt_valid", 32'(instr_valid), 32'd0);
      tick(); sample();
      chk("t2_done", 32'(done), 32'd1);
      tick(); sample();
      chk("t2_idle_busy", 32'(busy), 32'd0);
      chk("t2_count", 32'(instr_count), 32'd3);
      chk("t2_sb_drain", 32'(exp_q.size()), 32'd0);

      // Watchdog: algo 5, base 10, no HALT within MAX_INSTR words
      tick(); start = 1'b1; algo_sel = 3'd5; push_run(10, 4);
      tick(); start = 1'b0;
      tick(); tick(); tick(); tick(); sample();
      chk("t3_pre_error", 32'(error), 32'd0);
      tick(); sample();
      chk("t3_error", 32'(error), 32'd1);
      chk("t3_error_done", 32'(done), 32'd0);
      tick(); sample();
      chk("t3_idle_busy", 32'(busy), 32'd0);
      chk("t3_idle_valid", 32'(instr_valid), 32'd0);
      chk("t3_error_pulse", 32'(error), 32'd0);
      chk("t3_count", 32'(instr_count), 32'd4);
      chk("t3_sb_drain", 32'(exp_q.size()), 32'd0);
      tick(); sample();
      chk("t3_no_done", 32'(done), 32'd0);

      // Abort with the skid full: algo 0, base 0
      tick(); start = 1'b1; algo_sel = 3'd0; push_run(0, 2);
      tick(); start = 1'b0;
      tick(); tick();
      tick(); instr_ready = 1'b0;
      tick(); abort = 1'b1;
      sample();
      chk("t4_skid_word", 32'(instr_out), 32'(rom[1]));
      chk("t4_abort_error", 32'(error), 32'd0);
      chk("t4_abort_done", 32'(done), 32'd0);
      tick(); abort = 1'b0; instr_ready = 1'b1;
      sample();
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_valid", 32'(instr_valid), 32'd0);
      chk("t4_done", 32'(done), 32'd0);
      chk("t4_error", 32'(error), 32'd0);
      chk("t4_count_hold", 32'(instr_count), 32'd1);
      chk("t4_sb_left", 32'(exp_q.size()), 32'd1);
      exp_q.delete();

      // Relaunch with algo 7 while holding start and toggling algo_sel
      start = 1'b1; algo_sel = 3'd7; push_run(14, 2);
      for (int k = 0; k < 6; k++) begin
         tick();
         algo_sel = 3'(k) ^ 3'b101;
         sample();
         chk("t5_sel_pc", 32'(sel_pc), (k == 0) ? 32'd1 : 32'd0);
         chk("t5_sel_dir", 32'(sel_dir), 32'd7);
      end
      chk("t5_done", 32'(done), 32'd1);
      tick(); start = 1'b0;
      sample();
      chk("t5_idle_busy", 32'(busy), 32'd0);
      chk("t5_count", 32'(instr_count), 32'd2);
      chk("t5_sb_drain", 32'(exp_q.size()), 32'd0);
      tick(); sample();
      chk("t5_no_relaunch", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of RUN
      tick(); start = 1'b1; algo_sel = 3'd2; push_run(4, 3);
      tick(); start = 1'b0;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_valid", 32'(instr_valid), 32'd0);
      chk("t6_out", 32'(instr_out), 32'd0);
      chk("t6_pc_en", 32'(pc_en), 32'd0);
      chk("t6_sel_dir", 32'(sel_dir), 32'd0);
      chk("t6_count", 32'(instr_count), 32'd0);
      chk("t6_sb_left", 32'(exp_q.size()), 32'd2);
      exp_q.delete();
      tick(); rst_n = 1'b1;
      sample();
      chk("t6_post_busy", 32'(busy), 32'd0);
      chk("t6_post_sel_pc", 32'(sel_pc), 32'd0);
      tick(); start = 1'b1; algo_sel = 3'd3;
      tick(); start = 1'b0;
      sample();
      chk("t6_relaunch_sel_pc", 32'(sel_pc), 32'd1);
      chk("t6_relaunch_sel_dir", 32'(sel_dir), 32'd3);
      tick(); abort = 1'b1;
      tick(); abort = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
